// File: rtl/measurement_serializer.sv
// measurement_serializer
//   Captures one frame of NUM_MEAS parallel measurement words on a load
//   handshake and replays it as a valid/ready word stream, word 0 first.
//   Holds exactly one frame; no new load is accepted until the stream drains.
//   Optional: define MEAS_SER_CHECKSUM_EN to append one extra word holding
//   the modulo-2**WIDTH sum of the frame (out_idx = NUM_MEAS for that word).
module measurement_serializer #(
  parameter int NUM_MEAS = 48,
  parameter int WIDTH    = 16,
  parameter int IDX_W    = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [NUM_MEAS*WIDTH-1:0] meas_bus,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      frame_done,
  output logic [7:0]                frame_cnt
);

  typedef enum logic {IDLE, SEND} state_e;

`ifdef MEAS_SER_CHECKSUM_EN
  localparam int unsigned LAST_WORD = NUM_MEAS;
`else
  localparam int unsigned LAST_WORD = NUM_MEAS - 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_WORD);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    buf_q [NUM_MEAS];
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;

  logic                capture;
  logic                xfer;
  logic [IDX_W-1:0]    idx_inc;
  logic [WIDTH-1:0]    next_word;

  assign load_ready = (state_q == IDLE);
  assign capture    = load_valid && (state_q == IDLE);
  assign xfer       = out_valid_q && out_ready;
  assign idx_inc    = out_idx_q + IDX_W'(1);

`ifdef MEAS_SER_CHECKSUM_EN
  logic [WIDTH-1:0] sum_q, sum_d;

  // Sum of the incoming frame, computed once from the bus at capture
  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < NUM_MEAS; i++) begin
      sum_d = sum_d + meas_bus[i*WIDTH +: WIDTH];
    end
  end

  // Checksum register, loaded alongside the frame buffer
  always_ff @(posedge clk) begin
    if (capture) sum_q <= sum_d;
  end

  // Word following the current one: buffered data, or the checksum after the last data word
  always_comb begin
    next_word = '0;
    if (idx_inc == IDX_W'(NUM_MEAS)) next_word = sum_q;
    else if (idx_inc < IDX_W'(NUM_MEAS)) next_word = buf_q[idx_inc];
  end
`else
  // Word following the current one, taken from the frame buffer
  always_comb begin
    next_word = '0;
    if (idx_inc < IDX_W'(NUM_MEAS)) next_word = buf_q[idx_inc];
  end
`endif

  // Frame buffer: sampled only in the capture cycle, contents need no reset
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned i = 0; i < NUM_MEAS; i++) begin
        buf_q[i] <= meas_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: capture starts a frame, transfer of the last word ends it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (capture) state_d = SEND;
      SEND: if (xfer && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stream output next values: word 0 on capture, advance on each transfer, hold under backpressure
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_idx_d    = out_idx_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    if (capture) begin
      out_valid_d = 1'b1;
      out_idx_d   = '0;
      out_data_d  = meas_bus[WIDTH-1:0];
      out_last_d  = 1'b0;
    end else if (xfer) begin
      if (out_last_q) begin
        out_valid_d  = 1'b0;
        out_idx_d    = '0;
        out_last_d   = 1'b0;
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 8'd1;
      end else begin
        out_idx_d  = idx_inc;
        out_data_d = next_word;
        out_last_d = (idx_inc == LAST_IDX);
      end
    end
  end

  // Stream output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_idx_q    <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_idx_q    <= out_idx_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign out_idx    = out_idx_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_measurement_serializer.sv
// Directed bench for measurement_serializer: reset, streaming, backpressure,
// loads during SEND, mid-frame reset, checksum word and frame counter wrap.
module tb_measurement_serializer;

  localparam int NM = 48;
  localparam int W  = 16;
  localparam int IW = 6;
`ifdef MEAS_SER_CHECKSUM_EN
  localparam int FL = NM + 1;
`else
  localparam int FL = NM;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              load_valid;
  logic              load_ready;
  logic [NM*W-1:0]   meas_bus;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic [IW-1:0]     out_idx;
  logic              frame_done;
  logic [7:0]        frame_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [W-1:0] exp_words [FL];
  logic [7:0]   exp_cnt = 8'd0;

  measurement_serializer #(.NUM_MEAS(NM), .WIDTH(W), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .meas_bus(meas_bus), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_idx(out_idx),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic [W-1:0] base, input logic [W-1:0] step);
    for (int i = 0; i < NM; i++) meas_bus[i*W +: W] = base + W'(i) * step;
  endtask

  // Snapshot the bus as the expected frame; call just before the capture edge
  task automatic latch_expected();
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < NM; i++) begin
      exp_words[i] = meas_bus[i*W +: W];
      s = s + meas_bus[i*W +: W];
    end
`ifdef MEAS_SER_CHECKSUM_EN
    exp_words[NM] = s;
`endif
  endtask

  // Load the current bus: call with load_ready expected high
  task automatic do_load();
    latch_expected();
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  // Stream one captured frame. Starts right after the capture edge.
  task automatic stream(input int stall_idx, input int stall_len, input bit noise);
    for (int i = 0; i < FL; i++) begin
      if (noise) begin
        load_valid = (i == FL-1) ? 1'b1 : i[0];
        set_bus(16'hA000 + W'(i), 16'h0003);
      end
      if (i == 0) check("ready_low_in_send", {31'd0, load_ready}, 32'd0);
      if (i == stall_idx) begin
        out_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check("stall_data", {16'd0, out_data}, {16'd0, exp_words[i]});
          check("stall_idx", {26'd0, out_idx}, i);
          check("stall_last", {31'd0, out_last}, {31'd0, i == FL-1});
        end
        out_ready = 1'b1;
      end
      check("valid", {31'd0, out_valid}, 32'd1);
      check("data", {16'd0, out_data}, {16'd0, exp_words[i]});
      check("idx", {26'd0, out_idx}, i);
      check("last", {31'd0, out_last}, {31'd0, i == FL-1});
      tick();
    end
    exp_cnt = exp_cnt + 8'd1;
    check("end_valid", {31'd0, out_valid}, 32'd0);
    check("end_idx", {26'd0, out_idx}, 32'd0);
    check("end_last", {31'd0, out_last}, 32'd0);
    check("frame_done", {31'd0, frame_done}, 32'd1);
    check("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
    check("end_ready", {31'd0, load_ready}, 32'd1);
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b1;
    out_ready  = 1'b1;
    set_bus(16'h5555, 16'h0001);

    // 1: reset held with load_valid high
    tick(); tick();
    check("rst_ready", {31'd0, load_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_cnt", {24'd0, frame_cnt}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_idx", {26'd0, out_idx}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    load_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("no_capture", {31'd0, out_valid}, 32'd0);

    // 2: word i = 0x0100+i, continuous ready
    set_bus(16'h0100, 16'h0001);
    do_load();
    stream(-1, 0, 1'b0);
    tick();
    check("done_pulse_1cyc", {31'd0, frame_done}, 32'd0);

    // 3: backpressure of 3 cycles at idx 5
    set_bus(16'h0100, 16'h0001);
    do_load();
    stream(5, 3, 1'b0);

    // 4: noisy load_valid/bus during SEND, including the last transfer cycle
    set_bus(16'h2000, 16'h0011);
    do_load();
    stream(10, 2, 1'b1);
    // load_valid still high with new data; capture at this next edge
    latch_expected();
    tick();
    load_valid = 1'b0;
    check("recapture_word0", {16'd0, out_data}, {16'd0, exp_words[0]});
    stream(-1, 0, 1'b0);

    // 5: async reset at idx 20
    set_bus(16'h0100, 16'h0001);
    do_load();
    for (int i = 0; i < 20; i++) tick();
    check("pre_rst_idx", {26'd0, out_idx}, 32'd20);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_cnt", {24'd0, frame_cnt}, 32'd0);
    check("mid_rst_idx", {26'd0, out_idx}, 32'd0);
    check("mid_rst_ready", {31'd0, load_ready}, 32'd1);
    tick();
    check("mid_rst_done", {31'd0, frame_done}, 32'd0);
    reset = 1'b1;
    exp_cnt = 8'd0;
    tick();
    set_bus(16'h0300, 16'h0002);
    do_load();
    stream(-1, 0, 1'b0);

    // 6: all-ones frame (checksum 0xFFD0 when enabled) and counter wrap
    set_bus(16'hFFFF, 16'h0000);
    do_load();
`ifdef MEAS_SER_CHECKSUM_EN
    check("sum_expected", {16'd0, exp_words[NM]}, 32'h0000FFD0);
`endif
    stream(-1, 0, 1'b0);
    while (exp_cnt != 8'd255) begin
      do_load();
      for (int i = 0; i < FL; i++) tick();
      exp_cnt = exp_cnt + 8'd1;
    end
    check("cnt_255", {24'd0, frame_cnt}, 32'd255);
    do_load();
    stream(-1, 0, 1'b0);
    check("cnt_wrap", {24'd0, frame_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
